// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: PC source from Control,
// PC mux selects, pipeline-control FSM states and a hazard-match helper.
package cpu_pkg;

    // ID-stage PC source produced by Control
    localparam logic [2:0] PCSRC_SEQ = 3'd0;
    localparam logic [2:0] PCSRC_BR  = 3'd1;
    localparam logic [2:0] PCSRC_J   = 3'd2;
    localparam logic [2:0] PCSRC_JR  = 3'd3;

    // PC mux select
    localparam logic [2:0] PCSEL_PC4   = 3'd0;
    localparam logic [2:0] PCSEL_CONBA = 3'd1;
    localparam logic [2:0] PCSEL_JT    = 3'd2;
    localparam logic [2:0] PCSEL_RS    = 3'd3;
    localparam logic [2:0] PCSEL_ILLOP = 3'd4;
    localparam logic [2:0] PCSEL_XADR  = 3'd5;

    // Interrupt / trap tracking state
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_TRAP = 2'd2
    } ctrl_state_e;

    // True when register r is a real register read by the ID instruction
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [1:0] use_v);
        return (r != 5'd0) && ((use_v[0] && (r == rs)) || (use_v[1] && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall decision: load-use, plus ID-resolved branches and
// register jumps whose source is still being produced in EX or loaded in MEM.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [2:0] id_pcsrc,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_use,
    input  logic       ex_regwr,
    input  logic       ex_memrd,
    input  logic [4:0] ex_dst,
    input  logic       mem_memrd,
    input  logic [4:0] mem_dst,
    output logic       stall
);

    logic ex_hit;
    logic mem_hit;
    logic id_resolves;

    // Stall when ID needs a value not yet available to the ID-stage comparator / PC mux
    always_comb begin
        ex_hit      = reg_match(ex_dst, id_rs, id_rt, id_use);
        mem_hit     = reg_match(mem_dst, id_rs, id_rt, id_use);
        id_resolves = (id_pcsrc == PCSRC_BR) || (id_pcsrc == PCSRC_JR);
        stall       = (ex_regwr && ex_memrd && ex_hit)
                    || (id_resolves && ((ex_regwr && ex_hit) || (mem_memrd && mem_hit)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/redirect steering, interrupt deferral and
// exception/trap tracking, plus a saturating stall-cycle counter.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       id_pcsrc,
    input  logic             id_taken,
    input  logic             id_illegal,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [1:0]       id_use,
    input  logic             ex_regwr,
    input  logic             ex_memrd,
    input  logic [4:0]       ex_dst,
    input  logic             mem_memrd,
    input  logic [4:0]       mem_dst,
    input  logic             irq,
    input  logic             kernel,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [2:0]       pc_sel,
    output logic             xp_link,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_e      state_q, state_d;
    logic             kseen_q, kseen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;
    logic             take_irq;

    hazard_detect u_hazard (
        .id_pcsrc  (id_pcsrc),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use    (id_use),
        .ex_regwr  (ex_regwr),
        .ex_memrd  (ex_memrd),
        .ex_dst    (ex_dst),
        .mem_memrd (mem_memrd),
        .mem_dst   (mem_dst),
        .stall     (stall)
    );

    // Output steering (exception > stall > redirect/interrupt) and next-state logic
    always_comb begin
        state_d      = state_q;
        kseen_d      = kseen_q;
        cnt_d        = cnt_q;
        take_irq     = 1'b0;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pc_sel       = PCSEL_PC4;
        xp_link      = 1'b0;

        if (id_illegal) begin
            pc_sel      = PCSEL_XADR;
            xp_link     = 1'b1;
            if_id_flush = 1'b1;
        end else if (stall) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            case (id_pcsrc)
                PCSRC_BR: begin
                    if (id_taken) begin
                        pc_sel      = PCSEL_CONBA;
                        if_id_flush = 1'b1;
                    end
                end
                PCSRC_J: begin
                    pc_sel      = PCSEL_JT;
                    if_id_flush = 1'b1;
                end
                PCSRC_JR: begin
                    pc_sel      = PCSEL_RS;
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
            // A pending interrupt waits for a sequential, non-stalled slot
            if ((state_q == ST_PEND) && irq && (id_pcsrc == PCSRC_SEQ)) begin
                take_irq    = 1'b1;
                pc_sel      = PCSEL_ILLOP;
                xp_link     = 1'b1;
                if_id_flush = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                kseen_d = 1'b0;
                if (irq && !kernel) state_d = ST_PEND;
            end
            ST_PEND: begin
                kseen_d = 1'b0;
                if (!irq)          state_d = ST_RUN;
                else if (take_irq) state_d = ST_TRAP;
            end
            ST_TRAP: begin
                // Handler return: a kernel-mode cycle followed by a user-mode cycle
                if (kseen_q && !kernel) begin
                    state_d = ST_RUN;
                    kseen_d = 1'b0;
                end else if (kernel) begin
                    kseen_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                kseen_d = 1'b0;
            end
        endcase

        if (id_illegal) begin
            state_d = ST_TRAP;
            kseen_d = 1'b0;
        end

        // Reset cycles run the pipeline freely with no redirect
        if (reset) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pc_sel       = PCSEL_PC4;
            xp_link      = 1'b0;
        end
    end

    // State, handler-return tracker and stall counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            kseen_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kseen_q <= kseen_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (default and 4-bit counter)
// share all stimulus; combinational outputs sampled 1ns after the falling edge.
module tb_pipe_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  id_pcsrc;
    logic        id_taken, id_illegal;
    logic [4:0]  id_rs, id_rt;
    logic [1:0]  id_use;
    logic        ex_regwr, ex_memrd;
    logic [4:0]  ex_dst;
    logic        mem_memrd;
    logic [4:0]  mem_dst;
    logic        irq, kernel;
    logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, xp_link;
    logic [2:0]  pc_sel;
    logic [15:0] stall_count;
    logic        pc_we4, if_id_we4, if_id_flush4, id_ex_bubble4, xp_link4;
    logic [2:0]  pc_sel4;
    logic [3:0]  stall_count4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .id_pcsrc(id_pcsrc), .id_taken(id_taken),
        .id_illegal(id_illegal), .id_rs(id_rs), .id_rt(id_rt), .id_use(id_use),
        .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_dst(ex_dst),
        .mem_memrd(mem_memrd), .mem_dst(mem_dst), .irq(irq), .kernel(kernel),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pc_sel(pc_sel), .xp_link(xp_link),
        .stall_count(stall_count)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_pcsrc(id_pcsrc), .id_taken(id_taken),
        .id_illegal(id_illegal), .id_rs(id_rs), .id_rt(id_rt), .id_use(id_use),
        .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_dst(ex_dst),
        .mem_memrd(mem_memrd), .mem_dst(mem_dst), .irq(irq), .kernel(kernel),
        .pc_we(pc_we4), .if_id_we(if_id_we4), .if_id_flush(if_id_flush4),
        .id_ex_bubble(id_ex_bubble4), .pc_sel(pc_sel4), .xp_link(xp_link4),
        .stall_count(stall_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic idle();
        id_pcsrc = PCSRC_SEQ; id_taken = 0; id_illegal = 0;
        id_rs = 0; id_rt = 0; id_use = 2'b00;
        ex_regwr = 0; ex_memrd = 0; ex_dst = 0;
        mem_memrd = 0; mem_dst = 0; irq = 0; kernel = 0;
    endtask

    task automatic load_use();
        ex_memrd = 1; ex_regwr = 1; ex_dst = 5'd8; id_rs = 5'd8; id_use = 2'b01;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; idle();
        repeat (2) @(negedge clk);
        // Reset outputs even with a load-use hazard present
        load_use(); #1;
        chk("rst_pc_we", 32'(pc_we), 1);
        chk("rst_if_id_we", 32'(if_id_we), 1);
        chk("rst_bubble", 32'(id_ex_bubble), 0);
        chk("rst_flush", 32'(if_id_flush), 0);
        chk("rst_pc_sel", 32'(pc_sel), 0);
        chk("rst_xp_link", 32'(xp_link), 0);
        @(negedge clk); reset = 0; idle();
        chk("rst_cnt", 32'(stall_count), 0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_RUN));

        // Load-use stall
        load_use(); #1;
        chk("lu_pc_we", 32'(pc_we), 0);
        chk("lu_if_id_we", 32'(if_id_we), 0);
        chk("lu_bubble", 32'(id_ex_bubble), 1);
        chk("lu_flush", 32'(if_id_flush), 0);
        chk("lu_pc_sel", 32'(pc_sel), 0);
        @(negedge clk); idle();
        chk("lu_cnt", 32'(stall_count), 1);
        #1 chk("lu_release_pc_we", 32'(pc_we), 1);

        // $0 never matches; use bits gate the compare; ALU result needs no stall for seq
        @(negedge clk); load_use(); ex_dst = 0; id_rs = 0; #1;
        chk("zero_reg_pc_we", 32'(pc_we), 1);
        @(negedge clk); idle(); load_use(); id_use = 2'b10; id_rt = 5'd3; #1;
        chk("use_bit_pc_we", 32'(pc_we), 1);
        @(negedge clk); idle(); ex_regwr = 1; ex_dst = 5'd5; id_rs = 5'd5; id_use = 2'b01; #1;
        chk("alu_seq_pc_we", 32'(pc_we), 1);
        @(negedge clk); id_pcsrc = PCSRC_JR; #1;
        chk("jr_stall_pc_we", 32'(pc_we), 0);
        chk("jr_stall_sel", 32'(pc_sel), 0);

        // Branch after load in MEM
        @(negedge clk); idle();
        id_pcsrc = PCSRC_BR; mem_memrd = 1; mem_dst = 5'd9; id_rt = 5'd9; id_use = 2'b10; #1;
        chk("br_stall_pc_we", 32'(pc_we), 0);
        chk("br_stall_bubble", 32'(id_ex_bubble), 1);
        chk("br_stall_flush", 32'(if_id_flush), 0);
        @(negedge clk); mem_memrd = 0; id_taken = 1; #1;
        chk("br_sel", 32'(pc_sel), 1);
        chk("br_flush", 32'(if_id_flush), 1);
        chk("br_pc_we", 32'(pc_we), 1);
        @(negedge clk); idle();
        chk("cnt_after_br", 32'(stall_count), 3);
        id_pcsrc = PCSRC_BR; id_taken = 0; #1;
        chk("bnt_sel", 32'(pc_sel), 0);
        chk("bnt_flush", 32'(if_id_flush), 0);
        @(negedge clk); idle(); id_pcsrc = PCSRC_J; #1;
        chk("j_sel", 32'(pc_sel), 2);
        chk("j_flush", 32'(if_id_flush), 1);

        // irq while in kernel mode is not pended
        @(negedge clk); idle(); irq = 1; kernel = 1;
        @(negedge clk); idle();
        chk("kirq_state", 32'(dut.state_q), 32'(ST_RUN));

        // Interrupt deferral
        irq = 1; #1;
        chk("irq_first_sel", 32'(pc_sel), 0);
        chk("irq_first_xp", 32'(xp_link), 0);
        @(negedge clk);
        chk("pend_state", 32'(dut.state_q), 32'(ST_PEND));
        id_pcsrc = PCSRC_J; #1;
        chk("defer_sel", 32'(pc_sel), 2);
        chk("defer_xp", 32'(xp_link), 0);
        @(negedge clk); id_pcsrc = PCSRC_SEQ; #1;
        chk("take_sel", 32'(pc_sel), 4);
        chk("take_xp", 32'(xp_link), 1);
        chk("take_flush", 32'(if_id_flush), 1);
        chk("take_pc_we", 32'(pc_we), 1);
        @(negedge clk);
        chk("trap_state", 32'(dut.state_q), 32'(ST_TRAP));
        #1;
        chk("trap_ign_sel", 32'(pc_sel), 0);
        chk("trap_ign_xp", 32'(xp_link), 0);
        @(negedge clk); irq = 0; kernel = 1;
        @(negedge clk);
        chk("trap_k1_state", 32'(dut.state_q), 32'(ST_TRAP));
        kernel = 0;
        @(negedge clk);
        chk("trap_ret_state", 32'(dut.state_q), 32'(ST_RUN));

        // Pending interrupt dropped when irq falls
        irq = 1;
        @(negedge clk);
        chk("pd_state", 32'(dut.state_q), 32'(ST_PEND));
        irq = 0; #1;
        chk("pd_sel", 32'(pc_sel), 0);
        chk("pd_xp", 32'(xp_link), 0);
        @(negedge clk);
        chk("pd_back", 32'(dut.state_q), 32'(ST_RUN));

        // Exception beats load-use stall and pending interrupt
        irq = 1;
        @(negedge clk);
        chk("exc_pend", 32'(dut.state_q), 32'(ST_PEND));
        id_illegal = 1; load_use(); #1;
        chk("exc_sel", 32'(pc_sel), 5);
        chk("exc_xp", 32'(xp_link), 1);
        chk("exc_pc_we", 32'(pc_we), 1);
        chk("exc_bubble", 32'(id_ex_bubble), 0);
        chk("exc_flush", 32'(if_id_flush), 1);
        @(negedge clk);
        chk("exc_state", 32'(dut.state_q), 32'(ST_TRAP));
        chk("exc_cnt", 32'(stall_count), 3);
        idle(); kernel = 1;
        @(negedge clk); kernel = 0;
        @(negedge clk);
        chk("exc_ret", 32'(dut.state_q), 32'(ST_RUN));

        // Reset while pending
        irq = 1;
        @(negedge clk);
        chk("rp_pend", 32'(dut.state_q), 32'(ST_PEND));
        reset = 1; #1;
        chk("rp_sel", 32'(pc_sel), 0);
        chk("rp_xp", 32'(xp_link), 0);
        chk("rp_flush", 32'(if_id_flush), 0);
        @(negedge clk);
        chk("rp_state", 32'(dut.state_q), 32'(ST_RUN));
        chk("rp_cnt", 32'(stall_count), 0);
        chk("rp_cnt4", 32'(stall_count4), 0);
        reset = 0; irq = 0; #1;
        chk("rp_after_sel", 32'(pc_sel), 0);
        chk("rp_after_xp", 32'(xp_link), 0);

        // Counter saturation: 20 stall cycles
        @(negedge clk); load_use();
        repeat (20) @(negedge clk);
        idle();
        chk("sat_cnt4", 32'(stall_count4), 15);
        chk("cnt16_20", 32'(stall_count), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
